// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: mirrors CLINT/PLIC sources into mip and raises one trap at a time.
// Optional IRQ_EXT_SYNC_EN adds a 2-flop synchroniser on m_eip.
`ifndef XLEN
`define XLEN 32
`endif

module irq_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_sip,
  input  logic              m_tip,
  input  logic              m_eip,
  input  logic              mstatus_mie,
  input  logic              mie_msie,
  input  logic              mie_mtie,
  input  logic              mie_meie,
  input  logic              irq_ack,
  input  logic              mret,
  output logic              irq_req,
  output logic [`XLEN-1:0]  irq_cause,
  output logic [`XLEN-1:0]  mip
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StReq     = 2'b01,
    StService = 2'b10
  } state_e;

  state_e             state;
  logic               eip_s;
  logic [`XLEN-1:0]   mip_d;
  logic [`XLEN-1:0]   enable_mask;
  logic [`XLEN-1:0]   pend;
  logic               fire;
  logic [3:0]         code;
  logic [`XLEN-1:0]   cause_d;

`ifdef IRQ_EXT_SYNC_EN
  logic [1:0] eip_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eip_sync <= 2'b00;
    end else begin
      eip_sync <= {eip_sync[0], m_eip};
    end
  end

  assign eip_s = eip_sync[1];
`else
  assign eip_s = m_eip;
`endif

  always_comb begin
    mip_d       = '0;
    mip_d[11]   = eip_s;
    mip_d[7]    = m_tip;
    mip_d[3]    = m_sip;
    enable_mask = '0;
    enable_mask[11] = mie_meie;
    enable_mask[7]  = mie_mtie;
    enable_mask[3]  = mie_msie;
  end

  // Arbitration works on the registered mip, which gives the fixed two-edge latency.
  assign pend = mip & enable_mask;
  assign fire = mstatus_mie & (pend != '0);

  always_comb begin
    code = 4'd0;
    if (pend[11]) begin
      code = 4'd11;
    end else if (pend[3]) begin
      code = 4'd3;
    end else if (pend[7]) begin
      code = 4'd7;
    end
    cause_d            = '0;
    cause_d[`XLEN-1]   = 1'b1;
    cause_d[3:0]       = code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mip <= '0;
    end else begin
      mip <= mip_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (fire) begin
            state     <= StReq;
            irq_req   <= 1'b1;
            irq_cause <= cause_d;
          end
        end
        // Request and cause are frozen until the core takes the trap.
        StReq: begin
          if (irq_ack) begin
            state   <= StService;
            irq_req <= 1'b0;
          end
        end
        StService: begin
          if (mret) begin
            state <= StIdle;
          end
        end
        default: begin
          state   <= StIdle;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Randomised bench for irq_arbiter against a cycle-level behavioural model, plus directed scenarios.
`ifndef XLEN
`define XLEN 32
`endif

module tb_irq_arbiter;

`ifdef IRQ_EXT_SYNC_EN
  localparam int ExtDly = 2;
`else
  localparam int ExtDly = 0;
`endif

  localparam logic [8:0] Sip    = 9'h001;
  localparam logic [8:0] Tip    = 9'h002;
  localparam logic [8:0] Eip    = 9'h004;
  localparam logic [8:0] Gie    = 9'h008;
  localparam logic [8:0] Msie   = 9'h010;
  localparam logic [8:0] Mtie   = 9'h020;
  localparam logic [8:0] Meie   = 9'h040;
  localparam logic [8:0] Ack    = 9'h080;
  localparam logic [8:0] Mret   = 9'h100;
  localparam logic [8:0] SrcAll = Sip | Tip | Eip;
  localparam logic [8:0] EnAll  = Gie | Msie | Mtie | Meie;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sip = 1'b0, m_tip = 1'b0, m_eip = 1'b0;
  logic mstatus_mie = 1'b0, mie_msie = 1'b0, mie_mtie = 1'b0, mie_meie = 1'b0;
  logic irq_ack = 1'b0, mret = 1'b0;
  logic             irq_req;
  logic [`XLEN-1:0] irq_cause;
  logic [`XLEN-1:0] mip;

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase 0 = no trap outstanding, 1 = waiting for ack, 2 = handler running.
  int          phase_m;
  logic        req_m;
  logic [31:0] cause_m;
  logic [31:0] mip_m;
  logic        eip_line[$];

  irq_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_sip       (m_sip),
    .m_tip       (m_tip),
    .m_eip       (m_eip),
    .mstatus_mie (mstatus_mie),
    .mie_msie    (mie_msie),
    .mie_mtie    (mie_mtie),
    .mie_meie    (mie_meie),
    .irq_ack     (irq_ack),
    .mret        (mret),
    .irq_req     (irq_req),
    .irq_cause   (irq_cause),
    .mip         (mip)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    phase_m = 0;
    req_m   = 1'b0;
    cause_m = 32'h0;
    mip_m   = 32'h0;
    eip_line.delete();
    for (int i = 0; i < ExtDly; i++) eip_line.push_back(1'b0);
  endtask

  task automatic model_edge(input logic [8:0] v);
    int prio[3];
    logic [31:0] pend;
    logic e;
    prio = '{11, 3, 7};
    pend = 32'h0;
    if (v[4]) pend = pend | (mip_m & 32'h0000_0008);
    if (v[5]) pend = pend | (mip_m & 32'h0000_0080);
    if (v[6]) pend = pend | (mip_m & 32'h0000_0800);
    if (phase_m == 0) begin
      if (v[3] && pend != 0) begin
        phase_m = 1;
        req_m   = 1'b1;
        for (int i = 2; i >= 0; i--) if (pend[prio[i]]) cause_m = 32'h8000_0000 + prio[i];
      end
    end else if (phase_m == 1) begin
      if (v[7]) begin
        phase_m = 2;
        req_m   = 1'b0;
      end
    end else if (v[8]) begin
      phase_m = 0;
    end
    eip_line.push_back(v[2]);
    e = eip_line.pop_front();
    mip_m = (32'(e) << 11) | (32'(v[1]) << 7) | (32'(v[0]) << 3);
  endtask

  // Apply one cycle of inputs, clock it, and compare every output to the model.
  task automatic step(input logic [8:0] v);
    {mret, irq_ack, mie_meie, mie_mtie, mie_msie, mstatus_mie, m_eip, m_tip, m_sip} = v;
    @(posedge clk);
    #1;
    model_edge(v);
    check_eq("req", {31'h0, irq_req}, {31'h0, req_m});
    check_eq("mip", mip, mip_m);
    if (req_m) check_eq("cause", irq_cause, cause_m);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req", {31'h0, irq_req}, 32'h0);
    check_eq("rst_cause", irq_cause, 32'h0);
    check_eq("rst_mip", mip, 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [8:0] v;
    model_clear();
    do_reset();

    // Timer latency, ack, return.
    step(Gie | Mtie);
    step(Gie | Mtie);
    step(Gie | Mtie | Tip);
    check_eq("tip_lat1", {31'h0, irq_req}, 32'h0);
    step(Gie | Mtie | Tip);
    check_eq("tip_lat2", {31'h0, irq_req}, 32'h1);
    check_eq("tip_cause", irq_cause, 32'h8000_0007);
    step(Gie | Mtie | Tip);
    step(Gie | Mtie | Tip | Ack);
    check_eq("tip_ack", {31'h0, irq_req}, 32'h0);
    step(Gie | Mtie | Mret);
    step(Gie | Mtie);

    // All sources together: external wins, then software after external clears.
    for (int i = 0; i < 5; i++) step((EnAll & ~Gie) | SrcAll);
    step(EnAll | SrcAll);
    check_eq("all_cause", irq_cause, 32'h8000_000B);
    step(EnAll | SrcAll | Ack);
    for (int i = 0; i < 4; i++) step(EnAll | Sip | Tip);
    step(EnAll | Sip | Tip | Mret);
    step(EnAll | Sip | Tip);
    check_eq("next_req", {31'h0, irq_req}, 32'h1);
    check_eq("next_cause", irq_cause, 32'h8000_0003);

    // Sources and global enable drop while requesting: request holds.
    step(Msie);
    step(Msie);
    check_eq("hold_req", {31'h0, irq_req}, 32'h1);
    check_eq("hold_cause", irq_cause, 32'h8000_0003);
    step(Ack);
    step(Mret);

    // Globally masked for 50 cycles.
    for (int i = 0; i < 50; i++) step((EnAll & ~Gie) | SrcAll);
    check_eq("masked_req", {31'h0, irq_req}, 32'h0);
    check_eq("masked_mip", mip, 32'h0000_0888);

    // Reset while in service, sources still high.
    step(EnAll | SrcAll);
    step(EnAll | SrcAll | Ack);
    do_reset();
    step(EnAll | Sip | Tip);
    check_eq("rel_req1", {31'h0, irq_req}, 32'h0);
    step(EnAll | Sip | Tip);
    check_eq("rel_req2", {31'h0, irq_req}, 32'h1);
    step(EnAll | Ack);
    step(EnAll | Mret);
    for (int i = 0; i < 4; i++) step(EnAll);

    // External interrupt latency (bounded wait).
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      step(Gie | Meie | Eip);
      if (irq_req) n = i;
    end
    check_eq("eip_lat", 32'(n), 32'(2 + ExtDly));
    check_eq("eip_cause", irq_cause, 32'h8000_000B);
    step(Gie | Meie | Ack);
    step(Gie | Meie | Mret);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        v = 9'h0;
        v[0] = ($urandom_range(99) < 30);
        v[1] = ($urandom_range(99) < 30);
        v[2] = ($urandom_range(99) < 30);
        v[3] = ($urandom_range(99) < 85);
        v[4] = ($urandom_range(99) < 80);
        v[5] = ($urandom_range(99) < 80);
        v[6] = ($urandom_range(99) < 80);
        v[7] = ($urandom_range(99) < 35);
        v[8] = ($urandom_range(99) < 25);
        step(v);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
